switch_debounce16: RTL and testbench
====================================

Name: switch_debounce16

Overview:
- Input conditioning stage for the 16 IO-expander switches S1..S16.
- Synchronises each raw switch to CLK and debounces it with a per-channel stability counter.
- Outputs clean levels plus single-cycle rising and falling edge strobes.
- Sits directly upstream of the counter/LED logic, which consumes these strobes instead of edge-detecting raw switches itself.

Parameters:
- N, 16: number of switch channels (1..32).
- STABLE_COUNT, 8: consecutive SAMPLE_EN strobes on which the synchronised input must differ from the debounced level before the level flips (1..255).
- CNT_W, 8: width of each per-channel counter; must hold STABLE_COUNT.

Ports:
- CLK  input  1  system clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset.
- SAMPLE_EN  input  1  one-CLK-cycle sample strobe, derived externally from CLK_1MHz (e.g. 1 kHz); may be tied high.
- S_IN  input  N  raw asynchronous switch levels; bit 0 = S1.
- S_OUT  output  N  debounced switch levels.
- S_RE  output  N  debounced rising-edge strobe, one CLK cycle wide.
- S_FE  output  N  debounced falling-edge strobe, one CLK cycle wide.
- ANY_EDGE  output  1  OR of all bits of S_RE and S_FE, registered in the same cycle as the strobes.

Behaviour:
- Interface:
  - Single clock CLK.
  - Reset is synchronous and active-high on RST.
  - No asynchronous logic.
- Reset:
  - While RST=1 at a CLK edge, all of the following clear to 0: sync stages, counters, S_OUT, S_RE, S_FE, ANY_EDGE.
  - RST has priority over SAMPLE_EN and all other activity.
  - Reset mid-debounce discards the partial count.
  - No edge strobe is generated by reset itself, even if S_OUT was 1.
- Synchroniser:
  - Two flip-flops per bit: sync1 <= S_IN, sync2 <= sync1, updated every CLK cycle independent of SAMPLE_EN.
  - Only sync2 is used downstream.
- Debounce, per channel i, evaluated only in cycles with SAMPLE_EN=1:
  - If sync2[i] == S_OUT[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_COUNT-1: S_OUT[i] <= sync2[i], cnt[i] <= 0, and the matching strobe is set (S_RE[i] if the new level is 1, S_FE[i] if 0).
  - Else: cnt[i] <= cnt[i]+1.
  - With SAMPLE_EN=0, cnt and S_OUT hold.
- Strobes:
  - S_RE/S_FE/ANY_EDGE are registered.
  - High exactly in the first cycle S_OUT shows the new value.
  - Forced 0 in every other cycle, including when SAMPLE_EN stays high continuously.
  - S_RE[i] and S_FE[i] are never high together.
  - Multiple channels may strobe in the same cycle.
- Glitch rejection:
  - Any sample agreeing with S_OUT restarts that channel's count from 0.
  - Bounces shorter than STABLE_COUNT samples produce no output change.
- Latency:
  - A clean input step appears on S_OUT after the 2-cycle sync, then on the STABLE_COUNT-th subsequent SAMPLE_EN strobe.
  - With STABLE_COUNT=1, the first differing sample flips the output.
- Counter range: cnt never exceeds STABLE_COUNT-1; no wrap-around is possible.
- Channel independence: channels are fully independent; no cross-channel effects.

Test Plan:
- Reset values: assert RST for 3 cycles with S_IN=16'hFFFF -> S_OUT=0, S_RE=S_FE=0, ANY_EDGE=0 throughout; no strobe on deassert.
- Clean press: STABLE_COUNT=4, SAMPLE_EN every 10th cycle, S_IN[8] 0->1 held -> S_OUT[8] rises on the 4th strobe after sync; S_RE[8]=1 for exactly 1 cycle; ANY_EDGE=1 in the same cycle; no other bit changes.
- Bounce rejection: S_IN[9] toggles 1,0,1,0 every 7 samples for 3 samples each -> S_OUT[9] stays 0, no strobes; then held 1 for 4 samples -> single S_RE[9].
- Release and simultaneous edges: S_OUT[0]=1 and S_OUT[1]=0; drive S_IN[0]=0 and S_IN[1]=1 in the same cycle -> S_FE[0] and S_RE[1] asserted in the same single cycle.
- Continuous sample and minimum count: SAMPLE_EN tied 1, STABLE_COUNT=1, step S_IN[15] -> S_OUT[15] changes 3 cycles after the step; strobe lasts 1 cycle; counters never exceed 0.
- Reset mid-operation: S_IN[10]=1 held for 3 of 4 required samples, pulse RST for 1 cycle, keep S_IN[10]=1 -> S_OUT[10] rises only after 4 full post-reset strobes.

Source files
------------

// File: rtl/switch_debounce16.sv
// rtl/switch_debounce16.sv - two-flop synchroniser plus per-channel debounce with edge strobes
//
// Conditions the raw IO-expander switches for the counter/LED logic.
// Each channel is synchronised to CLK.
// The debounced level flips only after STABLE_COUNT consecutive SAMPLE_EN
// strobes on which the synchronised input disagrees with it.
// A registered one-cycle strobe marks every flip.
//
// Ports:
//   CLK        system clock, all state changes on its rising edge
//   RST        synchronous active-high reset
//   SAMPLE_EN  one-cycle debounce sample strobe (may be tied high)
//   S_IN       raw asynchronous switch levels, bit 0 = S1
//   S_OUT      debounced switch levels
//   S_RE       debounced rising-edge strobe, one cycle per flip
//   S_FE       debounced falling-edge strobe, one cycle per flip
//   ANY_EDGE   OR of all S_RE/S_FE bits, aligned with them

module switch_debounce16 #(
   parameter int N            = 16,
   parameter int STABLE_COUNT = 8,
   parameter int CNT_W        = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         SAMPLE_EN,
   input  logic [N-1:0] S_IN,
   output logic [N-1:0] S_OUT,
   output logic [N-1:0] S_RE,
   output logic [N-1:0] S_FE,
   output logic         ANY_EDGE
);

   // The last count value before a flip.
   // The counter never passes it, so it cannot wrap.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

   logic [N-1:0]     sync1_q, sync1_d;
   logic [N-1:0]     sync2_q, sync2_d;
   logic [N-1:0]     s_out_q, s_out_d;
   logic [N-1:0]     s_re_q,  s_re_d;
   logic [N-1:0]     s_fe_q,  s_fe_d;
   logic             any_edge_q, any_edge_d;
   logic [CNT_W-1:0] cnt_q [N];
   logic [CNT_W-1:0] cnt_d [N];

   always_comb begin
      sync1_d = S_IN;
      sync2_d = sync1_q;
      s_out_d = s_out_q;
      // Strobes default low, so they last exactly one cycle even with SAMPLE_EN held high.
      s_re_d  = '0;
      s_fe_d  = '0;
      for (int i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
         if (SAMPLE_EN) begin
            if (sync2_q[i] == s_out_q[i]) begin
               // Any agreeing sample restarts the stability window.
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               s_out_d[i] = sync2_q[i];
               cnt_d[i]   = '0;
               s_re_d[i]  = sync2_q[i];
               s_fe_d[i]  = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
      any_edge_d = |(s_re_d | s_fe_d);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         s_out_q    <= '0;
         s_re_q     <= '0;
         s_fe_q     <= '0;
         any_edge_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         s_out_q    <= s_out_d;
         s_re_q     <= s_re_d;
         s_fe_q     <= s_fe_d;
         any_edge_q <= any_edge_d;
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < N; i++) begin
         if (RST) begin
            cnt_q[i] <= '0;
         end else begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign S_OUT    = s_out_q;
   assign S_RE     = s_re_q;
   assign S_FE     = s_fe_q;
   assign ANY_EDGE = any_edge_q;

endmodule

// File: tb/tb_switch_debounce16.sv
// tb/tb_switch_debounce16.sv - scoreboard bench for switch_debounce16 (STABLE_COUNT 4 and 1)

module tb_switch_debounce16;

   typedef struct {
      int          cyc;
      logic [15:0] re;
      logic [15:0] fe;
      logic [15:0] out;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_en = 1'b0;
   logic [15:0] s_in4 = 16'hFFFF;
   logic [15:0] s_in1 = 16'hFFFF;
   logic [15:0] out4, re4, fe4, out1, re1, fe1;
   logic        any4, any1;
   int          cyc = 0;
   int          tests_run = 0;
   int          failed = 0;
   ev_t         q4[$];
   ev_t         q1[$];

   switch_debounce16 #(.N(16), .STABLE_COUNT(4), .CNT_W(8)) dut4 (
      .CLK(clk), .RST(rst), .SAMPLE_EN(sample_en), .S_IN(s_in4),
      .S_OUT(out4), .S_RE(re4), .S_FE(fe4), .ANY_EDGE(any4)
   );

   switch_debounce16 #(.N(16), .STABLE_COUNT(1), .CNT_W(8)) dut1 (
      .CLK(clk), .RST(rst), .SAMPLE_EN(1'b1), .S_IN(s_in1),
      .S_OUT(out1), .S_RE(re1), .S_FE(fe1), .ANY_EDGE(any1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input int c, input logic [15:0] r, input logic [15:0] f,
                              input logic [15:0] o);
      ev_t e;
      e.cyc = c;
      e.re  = r;
      e.fe  = f;
      e.out = o;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic at(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Posedges at cycles that are multiples of 10 carry SAMPLE_EN=1.
   initial forever begin
      @(negedge clk);
      sample_en = ((cyc + 1) % 10 == 0);
   end

   initial forever begin
      ev_t e;
      @(negedge clk);
      if (any4 || (|re4) || (|fe4)) begin
         if (q4.size() == 0) begin
            tests_run++;
            failed++;
            $display("FAIL dut4 unexpected strobe: re=%h fe=%h any=%b (cycle %0d) expected none",
                     re4, fe4, any4, cyc);
         end else begin
            e = q4.pop_front();
            check("dut4 strobe cycle", cyc, e.cyc);
            check("dut4 S_RE", re4, e.re);
            check("dut4 S_FE", fe4, e.fe);
            check("dut4 S_OUT", out4, e.out);
            check("dut4 ANY_EDGE", any4, 1);
         end
      end
   end

   initial forever begin
      ev_t e;
      @(negedge clk);
      if (any1 || (|re1) || (|fe1)) begin
         if (q1.size() == 0) begin
            tests_run++;
            failed++;
            $display("FAIL dut1 unexpected strobe: re=%h fe=%h any=%b (cycle %0d) expected none",
                     re1, fe1, any1, cyc);
         end else begin
            e = q1.pop_front();
            check("dut1 strobe cycle", cyc, e.cyc);
            check("dut1 S_RE", re1, e.re);
            check("dut1 S_FE", fe1, e.fe);
            check("dut1 S_OUT", out1, e.out);
            check("dut1 ANY_EDGE", any1, 1);
         end
      end
   end

   initial begin
      // Reset held three cycles with all switches high.
      for (int c = 1; c <= 3; c++) begin
         at(c);
         check("reset S_OUT", out4, 0);
         check("reset S_RE", re4, 0);
         check("reset S_FE", fe4, 0);
         check("reset ANY_EDGE", any4, 0);
         check("reset dut1 S_OUT", out1, 0);
      end
      rst   = 1'b0;
      s_in4 = 16'h0000;
      s_in1 = 16'h0000;

      // Clean press on S9: samples 110,120,130,140 -> flip at 140.
      at(100);
      s_in4[8] = 1'b1;
      q4.push_back(mk(140, 16'h0100, 16'h0000, 16'h0100));

      // S16 on the continuous-sample instance: visible 3 cycles after the step.
      s_in1[15] = 1'b1;
      q1.push_back(mk(103, 16'h8000, 16'h0000, 16'h8000));
      at(130);
      check("press not early", out4, 16'h0000);
      at(150);
      s_in1[15] = 1'b0;
      q1.push_back(mk(153, 16'h0000, 16'h8000, 16'h0000));

      // One-cycle pulse on S4 with STABLE_COUNT=1 -> back-to-back rise and fall.
      at(200);
      s_in1[3] = 1'b1;
      at(201);
      s_in1[3] = 1'b0;
      q1.push_back(mk(203, 16'h0008, 16'h0000, 16'h0008));
      q1.push_back(mk(204, 16'h0000, 16'h0008, 16'h0000));

      // Bounce on S10: two 3-sample high pulses, then a held level.
      at(200);
      s_in4[9] = 1'b1;
      at(230);
      s_in4[9] = 1'b0;
      at(270);
      s_in4[9] = 1'b1;
      at(300);
      s_in4[9] = 1'b0;
      at(390);
      check("bounce S_OUT held", out4, 16'h0100);
      at(400);
      s_in4[9] = 1'b1;
      q4.push_back(mk(440, 16'h0200, 16'h0000, 16'h0300));

      // Set S1, then release S1 and press S2 in the same cycle.
      at(500);
      s_in4[0] = 1'b1;
      q4.push_back(mk(540, 16'h0001, 16'h0000, 16'h0301));
      at(600);
      s_in4[0] = 1'b0;
      s_in4[1] = 1'b1;
      q4.push_back(mk(640, 16'h0002, 16'h0001, 16'h0302));

      // S11 gets 3 of 4 samples (710,720,730), then a one-cycle reset.
      at(700);
      s_in4[10] = 1'b1;
      at(730);
      rst = 1'b1;
      at(731);
      check("mid reset S_OUT", out4, 16'h0000);
      check("mid reset ANY_EDGE", any4, 0);
      rst = 1'b0;
      // Post-reset samples 740,750,760,770 -> all high inputs flip together at 770.
      q4.push_back(mk(770, 16'h0702, 16'h0000, 16'h0702));
      at(760);
      check("post reset not early", out4, 16'h0000);

      at(900);
      check("final dut4 S_OUT", out4, 16'h0702);
      check("final dut1 S_OUT", out1, 16'h0000);
      check("dut4 events left", q4.size(), 0);
      check("dut1 events left", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
